// File: rtl/decode_stage_pkg.sv
// Shared definitions for the pipelined add datapath: instruction field positions,
// ADD encoding and the decode-to-execute operand bundle.
package pa_pkg;

  localparam int unsigned PA_XLEN = 32;
  localparam int unsigned PA_RIDX = 5;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  typedef struct packed {
    logic [PA_XLEN-1:0] a;
    logic [PA_XLEN-1:0] b;
    logic [PA_RIDX-1:0] rd;
    logic [PA_XLEN-1:0] counter;
    logic               illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// NREG x XLEN register file: two asynchronous read ports, one synchronous write port,
// r0 reads as zero; synchronous active-low reset loads regs[i] = i.
module regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [RW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RW-1:0]   raddr_a_i,
  input  logic [RW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= XLEN'(i);
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage for R-type ADD: register read, scoreboard hazard stall, registered bundle.
// Optional writeback-to-operand forwarding: define DECODE_WB_BYPASS_EN.
module decode_stage
  import pa_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_counter,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [RW-1:0]   out_rd,
  output logic [XLEN-1:0] out_counter,
  output logic            out_illegal
);

  logic [5:0]      op, funct;
  logic [4:0]      shamt;
  logic [RW-1:0]   rs, rt, rd;
  logic            legal, hazard, accept;
  logic            rs_busy, rt_busy, rd_busy;
  logic            rs_fwd, rt_fwd;
  logic [XLEN-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  decoded_t        out_q, out_d;

  assign op    = in_instr[OP_MSB:OP_LSB];
  assign rs    = in_instr[RS_MSB:RS_LSB];
  assign rt    = in_instr[RT_MSB:RT_LSB];
  assign rd    = in_instr[RD_MSB:RD_LSB];
  assign shamt = in_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct = in_instr[FUNCT_MSB:FUNCT_LSB];

  assign legal = (op == OP_RTYPE) && (funct == FUNCT_ADD) && (shamt == '0);

  regfile #(.NREG(NREG), .XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign rs_fwd = wb_en && (wb_addr == rs) && (rs != '0);
  assign rt_fwd = wb_en && (wb_addr == rt) && (rt != '0);
`else
  assign rs_fwd = 1'b0;
  assign rt_fwd = 1'b0;
`endif

  assign opnd_a = rs_fwd ? wb_data : rf_a;
  assign opnd_b = rt_fwd ? wb_data : rf_b;

  // rd is never forwarded: a pending write to rd always stalls (WAW).
  assign rs_busy = (rs != '0) && busy_q[rs] && !rs_fwd;
  assign rt_busy = (rt != '0) && busy_q[rt] && !rt_fwd;
  assign rd_busy = (rd != '0) && busy_q[rd];
  assign hazard  = legal && (rs_busy || rt_busy || rd_busy);

  assign in_ready = rst_n && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy_d      = busy_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      if (legal) begin
        out_d = '{a: opnd_a, b: opnd_b, rd: rd, counter: in_counter, illegal: 1'b0};
        if (rd != '0) busy_d[rd] = 1'b1;
      end else begin
        out_d = '{a: '0, b: '0, rd: '0, counter: in_counter, illegal: 1'b1};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_rd      = out_q.rd;
  assign out_counter = out_q.counter;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage, with hand-written stall,
// back-pressure, r0 and reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, wb_en, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_counter, wb_data, out_a, out_b, out_counter;
  logic [4:0]  wb_addr, out_rd;

  int checks   = 0;
  int failures = 0;

  decode_stage #(.NREG(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_counter(in_counter), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_rd(out_rd), .out_counter(out_counter), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] counter;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] cnt, input logic il);
    chk({name, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, ".a"}, out_a, a);
    chk({name, ".b"}, out_b, b);
    chk({name, ".rd"}, {27'b0, out_rd}, {27'b0, rd});
    chk({name, ".counter"}, out_counter, cnt);
    chk({name, ".illegal"}, {31'b0, out_illegal}, {31'b0, il});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_counter = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #1;
    do_reset();
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.busy", dut.busy_q, 32'd0);

    // Back-to-back independent instructions at full throughput.
    vecs[0] = '{mk(1, 2, 20),      32'd100, 32'd1,  32'd2,  5'd20, 1'b0};
    vecs[1] = '{mk(3, 4, 21),      32'd101, 32'd3,  32'd4,  5'd21, 1'b0};
    vecs[2] = '{mk(31, 30, 22),    32'd102, 32'd31, 32'd30, 5'd22, 1'b0};
    vecs[3] = '{mk(0, 5, 0),       32'd103, 32'd0,  32'd5,  5'd0,  1'b0};
    vecs[4] = '{32'h20010005,      32'd104, 32'd0,  32'd0,  5'd0,  1'b1};
    vecs[5] = '{32'h00221821,      32'd105, 32'd0,  32'd0,  5'd0,  1'b1};
    vecs[6] = '{32'h00221860,      32'd106, 32'd0,  32'd0,  5'd0,  1'b1};
    vecs[7] = '{mk(6, 7, 23),      32'd107, 32'd6,  32'd7,  5'd23, 1'b0};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_counter = vecs[i].counter;
      #1;
      chk($sformatf("vec%0d.in_ready", i), {31'b0, in_ready}, 32'd1);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rd,
              vecs[i].counter, vecs[i].illegal);
    end
    in_valid = 1'b0;
    chk("vec.busy", dut.busy_q, 32'h00F0_0000);

    // RAW stall on $9 released by writeback.
    do_reset();
    in_valid = 1'b1; in_instr = 32'h004D4820; in_counter = 32'd0;
    tick();
    chk_out("add9", 32'd2, 32'd13, 5'd9, 32'd0, 1'b0);
    chk("add9.busy9", {31'b0, dut.busy_q[9]}, 32'd1);
    in_instr = 32'h00696820; in_counter = 32'd1;
    #1;
    chk("raw.stall0", {31'b0, in_ready}, 32'd0);
    tick();
    chk("raw.stall1", {31'b0, in_ready}, 32'd0);
    chk("raw.drained", {31'b0, out_valid}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'd15;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("raw.bypass_ready", {31'b0, in_ready}, 32'd1);
    tick();
    wb_en = 1'b0;
`else
    chk("raw.wb_cycle_stall", {31'b0, in_ready}, 32'd0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("raw.release", {31'b0, in_ready}, 32'd1);
    tick();
`endif
    in_valid = 1'b0;
    chk_out("add13", 32'd3, 32'd15, 5'd13, 32'd1, 1'b0);

    // Reset mid-stall: busy[9] set, out_valid held by back-pressure, concurrent writeback.
    in_valid = 1'b1; in_instr = mk(2, 3, 9); in_counter = 32'd2;
    tick();
    out_ready = 1'b0;
    in_instr = mk(9, 1, 5); in_counter = 32'd3;
    #1;
    chk("rstmid.stall", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEAD;
    #1;
    chk("rstmid.ready_low", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rstmid.valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid.a", out_a, 32'd0);
    chk("rstmid.b", out_b, 32'd0);
    chk("rstmid.rd", {27'b0, out_rd}, 32'd0);
    chk("rstmid.counter", out_counter, 32'd0);
    chk("rstmid.illegal", {31'b0, out_illegal}, 32'd0);
    chk("rstmid.busy", dut.busy_q, 32'd0);
    rst_n = 1'b1; wb_en = 1'b0; out_ready = 1'b1;
    in_instr = mk(9, 13, 0); in_counter = 32'd4;
    #1;
    chk("rstmid.ready_after", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("rstmid.reg9", 32'd9, 32'd13, 5'd0, 32'd4, 1'b0);

    // Back-pressure: first bundle holds, second emitted exactly once.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(1, 2, 0); in_counter = 32'd10;
    tick();
    in_instr = mk(4, 5, 0); in_counter = 32'd11;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp.ready%0d", c), {31'b0, in_ready}, 32'd0);
      chk_out($sformatf("bp.hold%0d", c), 32'd1, 32'd2, 5'd0, 32'd10, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp.second", 32'd4, 32'd5, 5'd0, 32'd11, 1'b0);
    tick();
    chk("bp.once", {31'b0, out_valid}, 32'd0);

    // Illegal instruction leaves the scoreboard untouched.
    in_valid = 1'b1; in_instr = 32'h20010005; in_counter = 32'd20;
    tick();
    chk_out("ill", 32'd0, 32'd0, 5'd0, 32'd20, 1'b1);
    chk("ill.busy", dut.busy_q, 32'd0);

    // Write to r0 dropped; r0 still reads zero.
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000FFFF;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = mk(0, 0, 1); in_counter = 32'd21;
    tick();
    in_valid = 1'b0;
    chk_out("r0", 32'd0, 32'd0, 5'd1, 32'd21, 1'b0);
    chk("r0.busy", dut.busy_q, 32'h0000_0002);

    // WAW on $1, and accept-set beats same-cycle writeback clear.
    in_valid = 1'b1; in_instr = mk(2, 3, 1); in_counter = 32'd22;
    #1;
    chk("waw.stall", {31'b0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd77;
    tick();
    wb_en = 1'b0;
    tick();
    chk_out("waw", 32'd2, 32'd3, 5'd1, 32'd22, 1'b0);
    in_instr = mk(4, 5, 6); in_counter = 32'd23;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'd66;
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("setwins.busy", dut.busy_q, 32'h0000_0042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the pipelined add datapath, directly downstream of instruction fetch. Accepts one 32-bit instruction plus its fetch counter per cycle and decodes the R-type ADD format (opcode 0, funct 6'b100000). Reads both source operands from a 32-entry register file and tracks pending destination writes in a scoreboard. Holds the stage when a hazard exists and emits a registered operand bundle to the execute stage.

## Interface
- `NREG`, 32: register file depth; register index width is `$clog2(NREG)` = 5.
- `XLEN`, 32: data and counter width.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: fetch presents an instruction.
- `in_ready`  out  1: the stage accepts the instruction this cycle.
- `in_instr`  in  32: instruction; fields are [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
- `in_counter`  in  XLEN: fetch counter of the instruction.
- `wb_en`, `wb_addr[4:0]`, `wb_data[XLEN-1:0]`  in: register-file write from writeback.
- `out_valid`  out  1; `out_ready`  in  1: output handshake to execute.
- `out_a`, `out_b`  out  XLEN: rs and rt operand values.
- `out_rd`  out  5: destination register.
- `out_counter`  out  XLEN: passthrough of the fetch counter.
- `out_illegal`  out  1: the instruction is not a legal ADD.

## Operation
- Reset (`rst_n`=0 at posedge) sets `regs[i]=i` and `busy=0`. It zeroes `out_valid`, `out_a`, `out_b`, `out_rd`, `out_counter` and `out_illegal`. Reset dominates a concurrent `wb_en` or in-flight handshake.
- Register 0 always reads 0. Writes to register 0 are dropped and never set `busy[0]`.
- An instruction is legal when op=0, funct=6'h20 and shamt=0.
- Hazard, legal instructions only: `busy[rs]` or `busy[rt]` or `busy[rd]`, counting only nonzero indices. Including `busy[rd]` blocks WAW, so at most one write per register is outstanding.
- `in_ready = rst_n & !hazard & (!out_valid | out_ready)`.
- Accept (`in_valid & in_ready`):
  - Load the output register.
  - Legal instruction: set `busy[rd]` when rd≠0.
  - Illegal instruction: set `out_illegal=1`, `out_a=out_b=0`, `out_rd=0`. Scoreboard unchanged.
- `out_valid` is set by an accept. It is cleared by `out_ready` when no new accept happens in the same cycle.
- Writeback: when `wb_en` is high, write `regs[wb_addr]` and clear `busy[wb_addr]` at the posedge.
  - If the same cycle accepts an instruction with rd==wb_addr, the set wins.
- Register writes and reads are ordered as write-then-read-next-cycle unless the bypass below is compiled in.
- Arithmetic: none in this stage. All fields are zero-extended passthroughs.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 per cycle with no hazard and `out_ready`=1.
- Back-pressure: with `out_valid & !out_ready`, the outputs hold stable and `in_ready`=0.
- A stall holds `in_ready`=0. Fetch must hold `in_instr` and `in_counter` stable while `in_valid & !in_ready`.
- A hazard releases in the cycle after the clearing writeback (without bypass). With bypass it releases in the same cycle.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A source is not hazardous when `wb_en & wb_addr==src & src≠0`.
  - The operand then takes `wb_data` combinationally, so the instruction is accepted in the writeback cycle.
  - `busy[rd]` is still checked against the scoreboard without bypass.
- Undefined: no forwarding. The source stalls until `busy` clears and the register-file read returns the new value one cycle after writeback.

## Structure
- The shared package `pa_pkg` holds:
  - the field position constants;
  - `OP_RTYPE=6'h00` and `FUNCT_ADD=6'h20`;
  - a `decoded_t` struct of {a, b, rd, counter, illegal}.
- One sub-module, `regfile`: NREG×XLEN, two asynchronous read ports, one synchronous write port, r0 hardwired to zero, and the synchronous active-low reset loading `regs[i]=i`.
- The scoreboard, hazard logic and output register live in `decode_stage`.

## Test plan
- Reset then `in_instr=32'h004D4820` (add $9,$2,$13), `in_counter=0`: after 1 cycle `out_valid=1`, `out_a=2`, `out_b=13`, `out_rd=9`, `out_counter=0`, and `busy[9]=1`.
- Then `32'h00696820` (add $13,$3,$9): `in_ready=0` while `busy[9]`. Drive `wb_en=1`, `wb_addr=9`, `wb_data=15`:
  - With bypass: accepted that cycle, `out_a=3`, `out_b=15`.
  - Without bypass: accepted the next cycle with the same values.
- Hold `out_ready=0` with two back-to-back instructions: the first bundle stays stable, `in_ready=0`, and the second is emitted exactly once after `out_ready=1`.
- `in_instr=32'h20010005` (op≠0): `out_illegal=1`, `out_rd=0`, and no `busy` bit set.
- `wb_en` to `wb_addr=0` with `wb_data=32'hFFFF`, then decode add $1,$0,$0: `out_a=out_b=0`.
- Assert `rst_n=0` mid-stall with `busy[9]=1` and `out_valid=1`: after the edge, all outputs are 0, `busy=0`, and `regs[9]=9`.
